// File: rtl/bcd_serial_addsub_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_pkg : shared BCD width, controller state encoding, digit helpers |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ADD  = 3'd2,
    CORR = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic [BCD_W-1:0] nines_comp(input logic [BCD_W-1:0] d);
    return BCD_W'(9) - d;
  endfunction

  function automatic logic is_bad_digit(input logic [BCD_W-1:0] d);
    return (d > BCD_W'(9));
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_serial_addsub_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_serial_addsub_ctrl_if : request/result bundle of the BCD sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface bcd_serial_addsub_ctrl_if #(
  parameter int NDIGITS = 4
);
  logic                   start;
  logic                   sub;
  logic [4*NDIGITS-1:0]   a;
  logic [4*NDIGITS-1:0]   b;
  logic [4*NDIGITS-1:0]   result;
  logic                   cout;
  logic                   neg;
  logic                   err;
  logic                   busy;
  logic                   done;

  modport master (
    output start, sub, a, b,
    input  result, cout, neg, err, busy, done
  );

  modport slave (
    input  start, sub, a, b,
    output result, cout, neg, err, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/bcd_serial_addsub_ctrl_digit_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_digit_add : combinational single-digit BCD adder with carry      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bcd_digit_add
  import bcd_pkg::*;
(
  input  wire logic [BCD_W-1:0] i_x,
  input  wire logic [BCD_W-1:0] i_y,
  input  wire logic             i_cin,
  output logic      [BCD_W-1:0] o_s,
  output logic                  o_cout
);

  logic [BCD_W:0] w_raw;

  assign w_raw  = {1'b0, i_x} + {1'b0, i_y} + {{BCD_W{1'b0}}, i_cin};
  assign o_cout = (w_raw > (BCD_W+1)'(9));
  // +6 skips the six unused codes; the wrap past 16 drops the decimal carry
  assign o_s    = o_cout ? (w_raw[BCD_W-1:0] + BCD_W'(6)) : w_raw[BCD_W-1:0];

endmodule
`default_nettype wire

// File: rtl/bcd_serial_addsub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_serial_addsub_ctrl : digit-serial BCD add/sub, sign + magnitude  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bcd_serial_addsub_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  bcd_serial_addsub_ctrl_if.slave bus
);

  localparam int              IW       = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int              W        = BCD_W * NDIGITS;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NDIGITS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [IW-1:0]     r_idx;
  logic              r_carry;
  logic              r_sub;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_result;
  logic              r_cout;
  logic              r_neg;
  logic              r_err;

  logic              w_bad;
  logic              w_last;
  logic [BCD_W-1:0]  w_da;
  logic [BCD_W-1:0]  w_db;
  logic [BCD_W-1:0]  w_dr;
  logic [BCD_W-1:0]  w_x;
  logic [BCD_W-1:0]  w_y;
  logic [BCD_W-1:0]  w_s;
  logic              w_co;

  always_comb begin
    w_bad = 1'b0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (is_bad_digit(bus.a[k*BCD_W +: BCD_W]) || is_bad_digit(bus.b[k*BCD_W +: BCD_W]))
        w_bad = 1'b1;
    end
  end

  assign w_last = (r_idx == LAST_IDX);

  // One adder serves both passes: ADD sees A and (complemented) B, CORR sees 9-result
  always_comb begin
    w_da = '0;
    w_db = '0;
    w_dr = '0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_da = r_a[k*BCD_W +: BCD_W];
        w_db = r_b[k*BCD_W +: BCD_W];
        w_dr = r_result[k*BCD_W +: BCD_W];
      end
    end
    if (r_state == CORR) begin
      w_x = nines_comp(w_dr);
      w_y = '0;
    end else begin
      w_x = w_da;
      w_y = r_sub ? nines_comp(w_db) : w_db;
    end
  end

  bcd_digit_add u_digit_add (
    .i_x    (w_x),
    .i_y    (w_y),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_next = LOAD;
      LOAD: w_next = w_bad ? DONE : ADD;
      ADD: begin
        if (w_last) begin
          if (r_sub && !w_co) w_next = CORR;
          else                w_next = DONE;
        end
      end
      CORR: if (w_last) w_next = DONE;
      DONE: w_next = bus.start ? LOAD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_sub    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_a      <= bus.a;
          r_b      <= bus.b;
          r_sub    <= bus.sub;
          r_result <= '0;
          r_cout   <= 1'b0;
          r_neg    <= 1'b0;
          r_err    <= w_bad;
          r_idx    <= '0;
          r_carry  <= bus.sub;
        end
        ADD: begin
          for (int k = 0; k < NDIGITS; k++)
            if (r_idx == IW'(k)) r_result[k*BCD_W +: BCD_W] <= w_s;
          r_carry <= w_co;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            if (!r_sub) begin
              r_cout <= w_co;
            end else if (!w_co) begin
              // No borrow-free carry out means A<B: ten's-complement the result
              r_neg   <= 1'b1;
              r_idx   <= '0;
              r_carry <= 1'b1;
            end
          end
        end
        CORR: begin
          for (int k = 0; k < NDIGITS; k++)
            if (r_idx == IW'(k)) r_result[k*BCD_W +: BCD_W] <= w_s;
          r_carry <= w_co;
          r_idx   <= r_idx + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.neg    = r_neg;
  assign bus.err    = r_err;
  assign bus.busy   = (r_state == LOAD) || (r_state == ADD) || (r_state == CORR);
  assign bus.done   = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_addsub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bcd_serial_addsub_ctrl : scoreboard bench for the BCD sequencer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bcd_serial_addsub_ctrl;

  localparam int ND = 4;
  localparam int W  = 4 * ND;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         neg;
    logic         err;
    logic [7:0]   lat;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bcd_serial_addsub_ctrl_if #(.NDIGITS(ND)) bus_if ();

  bcd_serial_addsub_ctrl #(.NDIGITS(ND)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  rec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic r_busy_ok;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < ND; k++) begin
      r[k*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic rec_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    rec_t e;
    int   av, bv, r;
    logic bad;
    av = 0; bv = 0; bad = 1'b0;
    for (int k = ND - 1; k >= 0; k--) begin
      if (a[k*4 +: 4] > 4'd9 || b[k*4 +: 4] > 4'd9) bad = 1'b1;
      av = av * 10 + int'(a[k*4 +: 4]);
      bv = bv * 10 + int'(b[k*4 +: 4]);
    end
    e = '0;
    e.lat = 8'(ND + 2);
    if (bad) begin
      e.err = 1'b1;
      e.lat = 8'd2;
    end else if (!s) begin
      r = av + bv;
      e.cout = (r >= 10**ND);
      e.res  = to_bcd(r % (10**ND));
    end else if (av >= bv) begin
      e.res = to_bcd(av - bv);
    end else begin
      e.res = to_bcd(bv - av);
      e.neg = 1'b1;
      e.lat = 8'(2*ND + 2);
    end
    return e;
  endfunction

  // Caller is positioned at a negedge; the next posedge samples start
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus_if.sub   = s;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.start = 1'b1;
    sb.push_back(model(s, a, b));
  endtask

  // Observes until done; lat counts negedges after the start-sampling edge
  task automatic collect(input int n0, output rec_t o);
    int n;
    bit seen;
    n = n0;
    seen = 0;
    r_busy_ok = 1'b1;
    o = '0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      n++;
      if (bus_if.done === 1'b1) seen = 1;
      else if (bus_if.busy !== 1'b1) r_busy_ok = 1'b0;
    end
    if (seen) begin
      o.res  = bus_if.result;
      o.cout = bus_if.cout;
      o.neg  = bus_if.neg;
      o.err  = bus_if.err;
      o.lat  = 8'(n);
    end
  endtask

  task automatic test_reset();
    bus_if.start = 1'b0; bus_if.sub = 1'b0; bus_if.a = '0; bus_if.b = '0;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus_if.result, bus_if.cout, bus_if.neg, bus_if.err, bus_if.busy, bus_if.done} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got res=%h c=%b n=%b e=%b busy=%b done=%b, want all 0",
               bus_if.result, bus_if.cout, bus_if.neg, bus_if.err, bus_if.busy, bus_if.done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", bus_if.busy, bus_if.done);
    end
  endtask

  task automatic run_table(input string name, input logic [W*2:0] tbl[], input bit chk_busy);
    rec_t o, e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      launch(tbl[i][W*2], tbl[i][W*2-1:W], tbl[i][W-1:0]);
      collect(0, o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s_%0d: got res=%h cout=%b neg=%b err=%b lat=%0d, want res=%h cout=%b neg=%b err=%b lat=%0d",
                 name, i, o.res, o.cout, o.neg, o.err, o.lat, e.res, e.cout, e.neg, e.err, e.lat);
      end
      if (chk_busy) begin
        n_cmp++;
        if (r_busy_ok !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_busy_%0d: got busy dropped before done, want busy high throughout", name, i);
        end
      end
    end
  endtask

  task automatic test_add();
    logic [W*2:0] t[];
    t = '{{1'b0, 16'h1234, 16'h5678}, {1'b0, 16'h9999, 16'h0001},
          {1'b0, 16'h0000, 16'h0000}, {1'b0, 16'h4095, 16'h5905}};
    run_table("add", t, 1'b0);
  endtask

  task automatic test_sub();
    logic [W*2:0] t[];
    t = '{{1'b1, 16'h5000, 16'h1234}, {1'b1, 16'h1234, 16'h1234},
          {1'b1, 16'h9999, 16'h0000}};
    run_table("sub", t, 1'b0);
  endtask

  task automatic test_sub_neg();
    logic [W*2:0] t[];
    t = '{{1'b1, 16'h1234, 16'h5000}, {1'b1, 16'h0000, 16'h0001},
          {1'b1, 16'h0000, 16'h9999}};
    run_table("subneg", t, 1'b1);
  endtask

  task automatic test_err();
    logic [W*2:0] t[];
    t = '{{1'b0, 16'h12A4, 16'h0000}, {1'b1, 16'h0001, 16'hF000}};
    run_table("err", t, 1'b0);
  endtask

  task automatic test_start_ignored();
    rec_t o, e;
    @(negedge clk);
    launch(1'b0, 16'h1234, 16'h5678);
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.sub   = 1'b1;
    bus_if.a     = 16'h9999;
    bus_if.b     = 16'h8888;
    collect(2, o);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin
      n_bad++;
      $display("FAIL start_ignored: got res=%h cout=%b neg=%b lat=%0d, want res=%h cout=%b neg=%b lat=%0d",
               o.res, o.cout, o.neg, o.lat, e.res, e.cout, e.neg, e.lat);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      n_bad++;
      $display("FAIL start_not_queued: got busy=%b done=%b, want 0 0", bus_if.busy, bus_if.done);
    end
  endtask

  task automatic test_back_to_back();
    rec_t o, e;
    logic [W*2:0] t[];
    t = '{{1'b0, 16'h4567, 16'h1111}, {1'b1, 16'h0100, 16'h0999},
          {1'b1, 16'h3000, 16'h0001}};
    @(negedge clk);
    for (int i = 0; i < t.size(); i++) begin
      launch(t[i][W*2], t[i][W*2-1:W], t[i][W-1:0]);
      collect(0, o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL b2b_%0d: got res=%h cout=%b neg=%b err=%b lat=%0d, want res=%h cout=%b neg=%b err=%b lat=%0d",
                 i, o.res, o.cout, o.neg, o.err, o.lat, e.res, e.cout, e.neg, e.err, e.lat);
      end
    end
  endtask

  task automatic test_reset_mid_corr();
    rec_t e;
    bit   saw_done;
    @(negedge clk);
    launch(1'b1, 16'h1234, 16'h5000);
    repeat (7) begin
      @(negedge clk);
      bus_if.start = 1'b0;
    end
    e = sb.pop_front();
    n_cmp++;
    if (bus_if.neg !== 1'b1 || bus_if.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_corr_state: got neg=%b busy=%b, want 1 1 (expected final res=%h)",
               bus_if.neg, bus_if.busy, e.res);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus_if.result, bus_if.cout, bus_if.neg, bus_if.err, bus_if.busy, bus_if.done} !== '0) begin
      n_bad++;
      $display("FAIL async_abort: got res=%h c=%b n=%b e=%b busy=%b done=%b, want all 0",
               bus_if.result, bus_if.cout, bus_if.neg, bus_if.err, bus_if.busy, bus_if.done);
    end
    saw_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) saw_done = 1;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) saw_done = 1;
    end
    n_cmp++;
    if (saw_done) begin
      n_bad++;
      $display("FAIL abort_no_done: got done pulse after abort, want none");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_sub_neg();
    test_err();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_corr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
